change_dispenser: RTL and testbench

Downstream stage of the vending machine controller. It consumes the per-coin change stream (`denomination code` + `valid`, plus the `no change` indication), buffers the codes in a FIFO, and drives the physical coin hoppers one coin at a time. Each ejection is confirmed through a coin-sense handshake, with timeout, retry and fault handling. It also keeps a wrapping count of dispensed coins and a sticky "no change" lamp.

---
 rtl/change_dispenser.sv | 156 +++++++++++++++
 tb/tb_change_dispenser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: buffers per-coin change codes in a FIFO and drives the coin hoppers
// one coin at a time, with sense confirmation, timeout/retry, fault and sticky indicators.
module change_dispenser #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned EJECT_CYCLES  = 4,
  parameter int unsigned SENSE_TIMEOUT = 1000,
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [3:0]                    i_change_denomination_code,
  input  logic                          i_change_valid,
  input  logic                          i_no_change,
  input  logic                          i_coin_sensed,
  input  logic                          i_fault_clear,
  output logic [3:0]                    o_hopper_sel,
  output logic                          o_eject,
  output logic                          o_fault,
  output logic [3:0]                    o_fault_code,
  output logic                          o_no_change_lamp,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [15:0]                   o_dispensed_count,
  output logic                          o_idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StEject, StWaitSense, StGap, StFault} state_e;

  state_e        state_q, state_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    cur_code_q, cur_code_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   retry_q, retry_d;
  logic          push_req, push_ok, pop, sensed_ok;

  assign push_req = i_change_valid & ~i_no_change & (i_change_denomination_code != 4'd0);
  assign pop      = (state_q == StIdle) && (count_q != '0);
  assign push_ok  = push_req && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign count_d  = count_q + CW'(push_ok) - CW'(pop);

  // cnt_q is a shared phase counter, zeroed on every state change.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    retry_d    = retry_q;
    cur_code_d = cur_code_q;
    sensed_ok  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pop) begin
          cur_code_d = mem_q[rd_ptr_q];
          retry_d    = '0;
          state_d    = StEject;
        end
      end
      StEject: begin
        if (i_coin_sensed) begin
          sensed_ok = 1'b1;
          cnt_d     = '0;
          state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else if (cnt_q == EJECT_CYCLES - 1) begin
          cnt_d   = '0;
          state_d = StWaitSense;
        end
      end
      StWaitSense: begin
        if (i_coin_sensed) begin
          sensed_ok = 1'b1;
          cnt_d     = '0;
          state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else if (cnt_q == SENSE_TIMEOUT - 1) begin
          cnt_d = '0;
          if (retry_q < MAX_RETRY) begin
            retry_d = retry_q + 32'd1;
            state_d = StEject;
          end else begin
            state_d = StFault;
          end
        end
      end
      StGap: begin
        if (cnt_q == GAP_CYCLES - 1) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StFault: begin
        cnt_d = '0;
        if (i_fault_clear) begin
          cur_code_d = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_change_denomination_code;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cur_code_q <= '0;
      cnt_q      <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cur_code_q <= cur_code_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Outputs are registered decodes of the current state, so they trail the state by one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_eject           <= 1'b0;
      o_hopper_sel      <= '0;
      o_fault           <= 1'b0;
      o_fault_code      <= '0;
      o_idle            <= 1'b0;
      o_dispensed_count <= '0;
      o_no_change_lamp  <= 1'b0;
      o_overflow        <= 1'b0;
    end else begin
      o_eject      <= (state_q == StEject);
      o_hopper_sel <= ((state_q == StEject) || (state_q == StWaitSense)) ? cur_code_q : 4'd0;
      o_fault      <= (state_q == StFault);
      o_fault_code <= (state_q == StFault) ? cur_code_q : 4'd0;
      o_idle       <= (state_q == StIdle) && (count_q == '0);
      if (sensed_ok) o_dispensed_count <= o_dispensed_count + 16'd1;
      if (i_change_valid && i_no_change) o_no_change_lamp <= 1'b1;
      else if (i_fault_clear)            o_no_change_lamp <= 1'b0;
      if (push_req && !push_ok)  o_overflow <= 1'b1;
      else if (i_fault_clear)    o_overflow <= 1'b0;
    end
  end

  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: scoreboard of queued codes checked against the
// hopper select whenever a coin is confirmed, plus timing and sticky-flag checks.
module tb_change_dispenser;
  localparam int unsigned FD = 16, EC = 4, ST = 1000, MR = 2, GC = 2;

  logic        i_clk, i_rst;
  logic [3:0]  code;
  logic        valid, no_change, sensed, fclear;
  logic [3:0]  o_hopper_sel, o_fault_code;
  logic        o_eject, o_fault, o_no_change_lamp, o_overflow, o_idle;
  logic [4:0]  o_fifo_count;
  logic [15:0] o_dispensed_count;

  int          n_cmp = 0, n_err = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  int          exp_disp = 0;
  int          peak = 0;
  logic [15:0] disp_prev = '0;

  change_dispenser #(
    .FIFO_DEPTH(FD), .EJECT_CYCLES(EC), .SENSE_TIMEOUT(ST), .MAX_RETRY(MR), .GAP_CYCLES(GC)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_change_denomination_code(code), .i_change_valid(valid), .i_no_change(no_change),
    .i_coin_sensed(sensed), .i_fault_clear(fclear),
    .o_hopper_sel(o_hopper_sel), .o_eject(o_eject), .o_fault(o_fault),
    .o_fault_code(o_fault_code), .o_no_change_lamp(o_no_change_lamp), .o_overflow(o_overflow),
    .o_fifo_count(o_fifo_count), .o_dispensed_count(o_dispensed_count), .o_idle(o_idle)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // A confirmed coin must carry the oldest outstanding code on the hopper select.
  always @(negedge i_clk) begin
    if (!i_rst && o_dispensed_count == disp_prev + 16'd1) begin
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else begin
        exp_code = exp_q.pop_front();
        check("sb_code", o_hopper_sel, exp_code);
      end
    end
    disp_prev = o_dispensed_count;
    if (int'(o_fifo_count) > peak) peak = o_fifo_count;
  end

  task automatic wait_eject(input logic lvl, input int budget, input string tag);
    for (int i = 0; i < budget && o_eject !== lvl; i++) @(negedge i_clk);
    check(tag, o_eject, lvl);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && o_idle !== 1'b1; i++) @(negedge i_clk);
    check(tag, o_idle, 1);
  endtask

  task automatic pulse_sense();
    sensed = 1'b1;
    @(negedge i_clk);
    sensed = 1'b0;
    exp_disp++;
  endtask

  initial begin
    logic [3:0] burst [5];
    int n, highs;
    burst = '{4'd2, 4'd6, 4'd6, 4'd9, 4'd15};
    i_rst = 1'b1; code = '0; valid = 0; no_change = 0; sensed = 0; fclear = 0;
    repeat (3) @(negedge i_clk);
    check("rst_eject", o_eject, 0);
    check("rst_sel", o_hopper_sel, 0);
    check("rst_fault", o_fault, 0);
    check("rst_count", o_fifo_count, 0);
    check("rst_disp", o_dispensed_count, 0);
    check("rst_idle", o_idle, 0);
    check("rst_lamp", o_no_change_lamp, 0);
    check("rst_ovf", o_overflow, 0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    check("idle_after_rst", o_idle, 1);

    // Single coin: eject high for 4 cycles starting two edges after the push edge.
    valid = 1; code = 4'd8; exp_q.push_back(4'd8);
    for (int i = 1; i <= 7; i++) begin
      @(negedge i_clk);
      if (i == 1) begin valid = 0; code = '0; end
      check("t1_eject", o_eject, (i >= 3 && i <= 6));
      if (i == 3) check("t1_sel", o_hopper_sel, 8);
    end
    repeat (2) @(negedge i_clk);
    pulse_sense();
    check("t1_disp", o_dispensed_count, exp_disp);
    wait_idle(6, "t1_idle");

    // Stray sense in IDLE is not counted.
    sensed = 1; @(negedge i_clk); sensed = 0; @(negedge i_clk);
    check("stray_disp", o_dispensed_count, exp_disp);

    // Burst of five codes, each confirmed as soon as its eject starts.
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      valid = 1; code = burst[i]; exp_q.push_back(burst[i]);
      @(negedge i_clk);
    end
    valid = 0; code = '0;
    for (int i = 0; i < 5; i++) begin
      wait_eject(1, 20, "burst_rise");
      pulse_sense();
      wait_eject(0, 10, "burst_fall");
    end
    wait_idle(10, "burst_idle");
    check("burst_peak", peak, 4);
    check("burst_disp", o_dispensed_count, exp_disp);

    // Timeout: three bursts separated by SENSE_TIMEOUT idle cycles, then fault.
    valid = 1; code = 4'd4; exp_q.push_back(4'd4);
    @(negedge i_clk);
    valid = 0; code = '0;
    wait_eject(1, 10, "to_rise");
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (o_eject === 1'b1 && n < 50) begin n++; @(negedge i_clk); end
      check("to_high", n, EC);
      n = 0;
      if (b < 2) begin
        while (o_eject === 1'b0 && n < 3000) begin n++; @(negedge i_clk); end
        check("to_gap", n, ST);
      end else begin
        while (o_fault === 1'b0 && n < 3000) begin n++; @(negedge i_clk); end
        check("to_fault_delay", n, ST);
      end
    end
    check("to_fault", o_fault, 1);
    check("to_fault_code", o_fault_code, 4);
    check("to_disp", o_dispensed_count, exp_disp);

    // Overflow while faulted: 16 accepted, 17th dropped.
    for (int i = 0; i < 17; i++) begin
      valid = 1; code = 4'((i % 15) + 1);
      if (i < 16) exp_q.push_back(4'((i % 15) + 1));
      @(negedge i_clk);
    end
    valid = 0; code = '0;
    @(negedge i_clk);
    check("ovf_count", o_fifo_count, 16);
    check("ovf_flag", o_overflow, 1);
    check("ovf_fault_held", o_fault, 1);
    fclear = 1; void'(exp_q.pop_front());
    @(negedge i_clk);
    fclear = 0;
    check("ovf_flag_clr", o_overflow, 0);
    for (int i = 0; i < 3 && o_fault !== 1'b0; i++) @(negedge i_clk);
    check("ovf_fault_clr", o_fault, 0);
    repeat (16) begin
      wait_eject(1, 20, "drain_rise");
      pulse_sense();
      wait_eject(0, 10, "drain_fall");
    end
    wait_idle(10, "drain_idle");
    check("drain_count", o_fifo_count, 0);
    check("drain_disp", o_dispensed_count, exp_disp);
    check("drain_sb_empty", exp_q.size(), 0);
    check("drain_fault_code", o_fault_code, 0);

    // Sense arriving exactly in the timeout cycle of the second burst counts as success.
    valid = 1; code = 4'd4; exp_q.push_back(4'd4);
    @(negedge i_clk);
    valid = 0; code = '0;
    wait_eject(1, 10, "late_rise1");
    wait_eject(0, 10, "late_fall1");
    wait_eject(1, ST + 10, "late_rise2");
    wait_eject(0, 10, "late_fall2");
    repeat (ST - 2) @(negedge i_clk);
    pulse_sense();
    check("late_disp", o_dispensed_count, exp_disp);
    wait_idle(10, "late_idle");
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_eject === 1'b1 || o_fault === 1'b1) highs++;
      @(negedge i_clk);
    end
    check("late_no_retry", highs, 0);

    // No-change indication lights the lamp without touching the FIFO.
    valid = 1; no_change = 1; code = '0;
    @(negedge i_clk);
    valid = 0; no_change = 0;
    check("nc_lamp", o_no_change_lamp, 1);
    check("nc_count", o_fifo_count, 0);
    valid = 1; code = '0;
    @(negedge i_clk);
    valid = 0;
    @(negedge i_clk);
    check("zero_code_count", o_fifo_count, 0);
    check("zero_code_idle", o_idle, 1);
    fclear = 1;
    @(negedge i_clk);
    fclear = 0;
    check("nc_lamp_clr", o_no_change_lamp, 0);

    // Reset in the middle of an eject with three codes still queued.
    for (int i = 0; i < 4; i++) begin
      valid = 1; code = 4'(3 + 4 * i);
      @(negedge i_clk);
    end
    valid = 0; code = '0;
    wait_eject(1, 10, "rst_mid_rise");
    check("rst_mid_queued", o_fifo_count, 3);
    i_rst = 1'b1;
    #1;
    check("rst_mid_eject", o_eject, 0);
    check("rst_mid_count", o_fifo_count, 0);
    check("rst_mid_sel", o_hopper_sel, 0);
    exp_q.delete();
    exp_disp = 0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_eject === 1'b1) highs++;
    end
    check("rst_mid_no_eject", highs, 0);
    check("rst_mid_idle", o_idle, 1);
    check("rst_mid_disp", o_dispensed_count, exp_disp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
